// File: rtl/wd_reset_ctrl.sv
// wd_reset_ctrl: counts unkicked watchdog timeouts, pre-warns, then drives a stretched reset request
module wd_reset_ctrl #(
  parameter int MISS_LIMIT = 3,
  parameter int RST_PULSE_CYCLES = 1000,
  parameter int HOLDOFF_CYCLES = 4096,
  parameter logic [15:0] KICK_KEY = 16'hA5C3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        timeout_irq,
  output logic        timer_ack,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        prewarn_irq,
  output logic        wd_reset_out
);
  localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ARMED, RESET_ASSERT, HOLDOFF} state_t;
  state_t state;
  logic irq_d, kicked, prewarn, key_err, wd_rst_occ, enable, prewarn_ie;
  logic tmo_evt, wr, kick_wr, kick_ok, clr_wr, kick_now;
  logic [3:0] miss_cnt, miss_nxt;
  logic [PW-1:0] pulse_cnt;
  logic [HW-1:0] hold_cnt;
  logic [15:0] status, rd_mux;
  assign prewarn_irq = prewarn & prewarn_ie;
  // decode bus strobes, timeout edge and the read mux
  always_comb begin
    tmo_evt = timeout_irq & ~irq_d;
    wr = chipselect & ~write_n;
    kick_wr = wr & (address == 2'd0);
    kick_ok = kick_wr & (writedata == KICK_KEY);
    clr_wr = wr & (address == 2'd2);
    kick_now = kicked | kick_ok;
    miss_nxt = miss_cnt + 4'd1;
    status = {6'd0, state, wd_rst_occ, key_err, prewarn, kicked, miss_cnt};
    rd_mux = address == 2'd0 ? status : address == 2'd1 ? {14'd0, prewarn_ie, enable} : 16'd0;
  end
  // irq edge capture, timer ack, control register, key error flag and registered read data
  always_ff @(posedge clk)
    if (reset) begin
      irq_d <= 1'b0;
      timer_ack <= 1'b0;
      enable <= 1'b0;
      prewarn_ie <= 1'b0;
      key_err <= 1'b0;
      readdata <= 16'd0;
    end else begin
      irq_d <= timeout_irq;
      timer_ack <= tmo_evt;
      if (wr && address == 2'd1) {prewarn_ie, enable} <= writedata[1:0];
      key_err <= (kick_wr & ~kick_ok) | (key_err & ~(clr_wr & writedata[6]));
      readdata <= (chipselect & write_n) ? rd_mux : 16'd0;
    end
  // watchdog FSM; later assignments to the sticky flags win so a set beats a same-cycle clear
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      miss_cnt <= 4'd0;
      kicked <= 1'b0;
      prewarn <= 1'b0;
      wd_rst_occ <= 1'b0;
      wd_reset_out <= 1'b0;
      pulse_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      prewarn <= prewarn & ~(clr_wr & writedata[5]);
      wd_rst_occ <= wd_rst_occ & ~(clr_wr & writedata[7]);
      case (state)
        IDLE: begin
          kicked <= 1'b0;
          miss_cnt <= 4'd0;
          if (enable) state <= ARMED;
        end
        ARMED:
          if (tmo_evt) begin
            if (kick_now) begin
              miss_cnt <= 4'd0;
              kicked <= 1'b0;
              prewarn <= 1'b0;
            end else begin
              miss_cnt <= miss_nxt;
              if (miss_nxt == 4'(MISS_LIMIT - 1)) prewarn <= 1'b1;
              if (miss_nxt == 4'(MISS_LIMIT)) begin
                state <= RESET_ASSERT;
                pulse_cnt <= PW'(RST_PULSE_CYCLES);
                wd_reset_out <= 1'b1;
                wd_rst_occ <= 1'b1;
              end
            end
          end else begin
            if (kick_ok) kicked <= 1'b1;
            if (!enable) state <= IDLE;
          end
        RESET_ASSERT: begin
          if (kick_ok) kicked <= 1'b1;
          if (pulse_cnt == PW'(1)) begin
            state <= HOLDOFF;
            wd_reset_out <= 1'b0;
            hold_cnt <= HW'(HOLDOFF_CYCLES);
            miss_cnt <= 4'd0;
            kicked <= 1'b0;
            prewarn <= 1'b0;
          end else pulse_cnt <= pulse_cnt - PW'(1);
        end
        HOLDOFF: begin
          if (kick_ok) kicked <= 1'b1;
          if (hold_cnt == HW'(1)) state <= enable ? ARMED : IDLE;
          else hold_cnt <= hold_cnt - HW'(1);
        end
      endcase
    end
endmodule
